branch_target_buffer_sa: RTL



---
 rtl/btb_pkg.sv | 41 ++++
 rtl/btb_set.sv | 116 +++++++++++
 rtl/branch_target_buffer_sa.sv | 97 +++++++++
 3 files changed

// File: rtl/btb_pkg.sv
// Shared types and helpers for the set-associative branch target buffer.
// Entry layout, saturating counter arithmetic and PC index/tag extraction.
package btb_pkg;

  // Field widths of btb_entry_t for the default build (32-bit PC, 16 sets,
  // 2-bit counters). btb_set stores the same fields at its own widths.
  localparam int BTB_DEF_PC_W  = 32;
  localparam int BTB_DEF_TAG_W = 26;
  localparam int BTB_DEF_CTR_W = 2;

  typedef struct packed {
    logic                     valid;
    logic [BTB_DEF_TAG_W-1:0] tag;
    logic [BTB_DEF_PC_W-1:0]  target;
    logic [BTB_DEF_CTR_W-1:0] ctr;
  } btb_entry_t;

  // Saturating increment of a w-bit counter carried in 32 bits.
  function automatic logic [31:0] ctr_inc(input logic [31:0] c, input int w);
    logic [31:0] max_v;
    max_v = (32'd1 << w) - 32'd1;
    return (c >= max_v) ? c : c + 32'd1;
  endfunction

  // Saturating decrement, floor at zero.
  function automatic logic [31:0] ctr_dec(input logic [31:0] c, input int w);
    if (w < 1) return c;
    return (c == 32'd0) ? c : c - 32'd1;
  endfunction

  // Set index lives just above the byte offset: pc[idx_w+1:2].
  function automatic logic [63:0] pc_index(input logic [63:0] p, input int idx_w);
    return (p >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  // Tag is everything above the index.
  function automatic logic [63:0] pc_tag(input logic [63:0] p, input int idx_w);
    return p >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/btb_set.sv
// One BTB set: NUM_WAYS entries plus a round-robin eviction pointer.
// Provides a lookup port (fetch PC) and an update-side probe (resolved PC),
// and applies the commit/allocate rules on the clock edge.
module btb_set
  import btb_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int TAG_W    = 26,
  parameter int NUM_WAYS = 2,
  parameter int CTR_W    = 2
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             flush,
  input  logic [TAG_W-1:0] i_lkp_tag,
  output logic             o_lkp_hit,
  output logic [PC_W-1:0]  o_lkp_target,
  output logic             o_lkp_pred,
  input  logic             i_upd_en,
  input  logic [TAG_W-1:0] i_upd_tag,
  input  logic             i_upd_taken,
  input  logic [PC_W-1:0]  i_upd_target,
  output logic             o_upd_hit,
  output logic             o_upd_pred
);

  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(32'd1 << (CTR_W - 1));

  logic [NUM_WAYS-1:0] r_valid;
  logic [TAG_W-1:0]    r_tag    [NUM_WAYS];
  logic [PC_W-1:0]     r_target [NUM_WAYS];
  logic [CTR_W-1:0]    r_ctr    [NUM_WAYS];
  logic [WAY_W-1:0]    r_ptr;

  logic             w_upd_hit;
  logic [WAY_W-1:0] w_upd_way;
  logic [WAY_W-1:0] w_victim;
  logic             w_free;

  // Fetch-side lookup: tags are unique within a set, so at most one way matches.
  always_comb begin
    o_lkp_hit    = 1'b0;
    o_lkp_target = '0;
    o_lkp_pred   = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (r_valid[w] && (r_tag[w] == i_lkp_tag)) begin
        o_lkp_hit    = 1'b1;
        o_lkp_target = r_target[w];
        o_lkp_pred   = r_ctr[w][CTR_W-1];
      end
    end
  end

  // Update-side probe: which way (if any) holds the resolved branch.
  always_comb begin
    w_upd_hit  = 1'b0;
    w_upd_way  = '0;
    o_upd_pred = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (r_valid[w] && (r_tag[w] == i_upd_tag)) begin
        w_upd_hit  = 1'b1;
        w_upd_way  = WAY_W'(w);
        o_upd_pred = r_ctr[w][CTR_W-1];
      end
    end
  end

  assign o_upd_hit = w_upd_hit;

  // Victim choice: lowest invalid way, else the round-robin pointer.
  always_comb begin
    w_victim = r_ptr;
    w_free   = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!w_free && !r_valid[w]) begin
        w_victim = WAY_W'(w);
        w_free   = 1'b1;
      end
    end
  end

  // Entry state: reset clears everything, flush drops valids and pointer,
  // otherwise train on hit or allocate on a taken miss.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_valid <= '0;
      r_ptr   <= '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
        r_tag[w]    <= '0;
        r_target[w] <= '0;
        r_ctr[w]    <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
      r_ptr   <= '0;
    end else if (i_upd_en) begin
      if (w_upd_hit) begin
        if (i_upd_taken) begin
          r_ctr[w_upd_way]    <= CTR_W'(ctr_inc(32'(r_ctr[w_upd_way]), CTR_W));
          r_target[w_upd_way] <= i_upd_target;
        end else begin
          r_ctr[w_upd_way] <= CTR_W'(ctr_dec(32'(r_ctr[w_upd_way]), CTR_W));
        end
      end else if (i_upd_taken) begin
        r_valid[w_victim]  <= 1'b1;
        r_tag[w_victim]    <= i_upd_tag;
        r_target[w_victim] <= i_upd_target;
        r_ctr[w_victim]    <= CTR_WEAK;
        // Pointer only moves when it actually picked the victim.
        if (!w_free && (NUM_WAYS > 1)) r_ptr <= r_ptr + WAY_W'(1);
      end
    end
  end

endmodule

// File: rtl/branch_target_buffer_sa.sv
// Set-associative branch target buffer for the fetch stage.
// Same-cycle lookup of target/taken prediction, saturating-counter training
// on commit, per-set round-robin replacement and synchronous flush.
// Optional build macro BTB_STATS_EN adds update and mispredict counters.
module branch_target_buffer_sa
  import btb_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 2,
  parameter int CTR_W    = 2
) (
  input  logic            clk,
  input  logic            clear_n,
  input  logic            flush,
  input  logic [PC_W-1:0] pc,
  input  logic            update_en,
  input  logic            update_outcome,
  input  logic [PC_W-1:0] update_pc,
  input  logic [PC_W-1:0] update_target,
  output logic [PC_W-1:0] target,
  output logic            pred,
  output logic            hit
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]     stat_updates,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic [IDX_W-1:0] w_lkp_idx;
  logic [TAG_W-1:0] w_lkp_tag;
  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;

  logic            w_set_hit    [NUM_SETS];
  logic [PC_W-1:0] w_set_target [NUM_SETS];
  logic            w_set_pred   [NUM_SETS];
  logic            w_set_uhit   [NUM_SETS];
  logic            w_set_upred  [NUM_SETS];

  assign w_lkp_idx = IDX_W'(pc_index(64'(pc), IDX_W));
  assign w_lkp_tag = TAG_W'(pc_tag(64'(pc), IDX_W));
  assign w_upd_idx = IDX_W'(pc_index(64'(update_pc), IDX_W));
  assign w_upd_tag = TAG_W'(pc_tag(64'(update_pc), IDX_W));

  for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
    btb_set #(
      .PC_W    (PC_W),
      .TAG_W   (TAG_W),
      .NUM_WAYS(NUM_WAYS),
      .CTR_W   (CTR_W)
    ) u_set (
      .clk         (clk),
      .clear_n     (clear_n),
      .flush       (flush),
      .i_lkp_tag   (w_lkp_tag),
      .o_lkp_hit   (w_set_hit[s]),
      .o_lkp_target(w_set_target[s]),
      .o_lkp_pred  (w_set_pred[s]),
      .i_upd_en    (update_en && (w_upd_idx == IDX_W'(s))),
      .i_upd_tag   (w_upd_tag),
      .i_upd_taken (update_outcome),
      .i_upd_target(update_target),
      .o_upd_hit   (w_set_uhit[s]),
      .o_upd_pred  (w_set_upred[s])
    );
  end

  assign hit    = w_set_hit[w_lkp_idx];
  assign pred   = hit & w_set_pred[w_lkp_idx];
  assign target = hit ? w_set_target[w_lkp_idx] : pc + PC_W'(4);

`ifdef BTB_STATS_EN
  logic w_upd_predicted;
  assign w_upd_predicted = w_set_uhit[w_upd_idx] & w_set_upred[w_upd_idx];

  // Saturating statistics; survive flush, cleared only by reset.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else if (update_en && !flush) begin
      if (stat_updates != '1) stat_updates <= stat_updates + 32'd1;
      if ((w_upd_predicted != update_outcome) && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`else
  logic w_unused_upd;
  assign w_unused_upd = w_set_uhit[w_upd_idx] ^ w_set_upred[w_upd_idx];
`endif

endmodule
